// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - shared types and default sizes for the RGB fade sequencer
package rgb_seq_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_NUM_STEPS = 4;
    localparam int DEF_DIV_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] r;
        logic [DEF_WIDTH-1:0] g;
        logic [DEF_WIDTH-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_channel_stepper.sv
// rtl/rgb_channel_stepper.sv - one duty channel that walks 1 LSB toward its target
module rgb_channel_stepper #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] duty,
    output logic             at_target
);

    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;

    // Move one LSB toward the target; comparisons first so the value never overshoots or wraps
    always_comb begin
        duty_d = duty_q;
        if (step_en) begin
            if (duty_q < target) begin
                duty_d = duty_q + WIDTH'(1);
            end else if (duty_q > target) begin
                duty_d = duty_q - WIDTH'(1);
            end
        end
    end

    // Duty register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty      = duty_q;
    assign at_target = (duty_q == target);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - palette-driven RGB fade/hold sequencer (optional RGB_SEQ_PINGPONG_EN: bounce step order)
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int DIV_W     = DEF_DIV_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         period_tick,
    input  logic [DIV_W-1:0]             step_div,
    input  logic [DIV_W-1:0]             hold_ticks,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
    input  logic [3*WIDTH-1:0]           cfg_data,
    output logic [WIDTH-1:0]             duty_r,
    output logic [WIDTH-1:0]             duty_g,
    output logic [WIDTH-1:0]             duty_b,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy,
    output logic                         step_done
);

    localparam int IDX_W = $clog2(NUM_STEPS);

    seq_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             step_en;

    logic [3*WIDTH-1:0] pal_q [NUM_STEPS];
    logic [3*WIDTH-1:0] target;
    logic               at_r, at_g, at_b;
    logic               all_at;
    logic [IDX_W-1:0]   idx_next;

`ifdef RGB_SEQ_PINGPONG_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
    logic dir_down_q, dir_down_d;

    // Bounce between the ends; the direction flips on the step that leaves an end
    always_comb begin
        dir_down_d = dir_down_q;
        if (!dir_down_q) begin
            if (idx_q == LAST_IDX) begin
                idx_next   = idx_q - IDX_W'(1);
                dir_down_d = 1'b1;
            end else begin
                idx_next   = idx_q + IDX_W'(1);
            end
        end else begin
            if (idx_q == '0) begin
                idx_next   = idx_q + IDX_W'(1);
                dir_down_d = 1'b0;
            end else begin
                idx_next   = idx_q - IDX_W'(1);
            end
        end
    end

    // Direction register, only updated when the index actually advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_down_q <= 1'b0;
        end else if (done_d) begin
            dir_down_q <= dir_down_d;
        end
    end
`else
    // Power-of-two depth makes the natural binary wrap the modulo step
    always_comb begin
        idx_next = idx_q + IDX_W'(1);
    end
`endif

    assign target = pal_q[idx_q];
    assign all_at = at_r & at_g & at_b;

    // Sequencer control: enable low forces IDLE; fades are paced by the divider, holds by ticks
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        step_en = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            div_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FADE;
                end
                FADE: begin
                    if (all_at) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else if (period_tick) begin
                        if (div_q == step_div) begin
                            div_d   = '0;
                            step_en = 1'b1;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (period_tick) begin
                        if (hold_q == hold_ticks) begin
                            idx_d   = idx_next;
                            done_d  = 1'b1;
                            state_d = FADE;
                            div_d   = '0;
                        end else begin
                            hold_d = hold_q + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Palette storage; a write lands at the edge so same-cycle reads still see the old colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pal_q[i] <= '0;
            end
        end else if (cfg_we) begin
            pal_q[cfg_addr] <= cfg_data;
        end
    end

    rgb_channel_stepper #(.WIDTH(WIDTH)) u_step_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .target    (target[3*WIDTH-1:2*WIDTH]),
        .duty      (duty_r),
        .at_target (at_r)
    );

    rgb_channel_stepper #(.WIDTH(WIDTH)) u_step_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .target    (target[2*WIDTH-1:WIDTH]),
        .duty      (duty_g),
        .at_target (at_g)
    );

    rgb_channel_stepper #(.WIDTH(WIDTH)) u_step_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .target    (target[WIDTH-1:0]),
        .duty      (duty_b),
        .at_target (at_b)
    );

    assign step_idx  = idx_q;
    assign busy      = (state_q != IDLE);
    assign step_done = done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - self-checking bench for rgb_fade_sequencer
module tb_rgb_fade_sequencer;

    localparam int N      = 4;
    localparam int M_IDLE = 0;
    localparam int M_FADE = 1;
    localparam int M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        period_tick = 1'b0;
    logic [7:0]  step_div = '0;
    logic [7:0]  hold_ticks = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [23:0] cfg_data = '0;
    logic [7:0]  duty_r, duty_g, duty_b;
    logic [1:0]  step_idx;
    logic        busy, step_done;

    int errors = 0;
    int checks = 0;

    int m_duty [3];
    int m_pal  [N][3];
    int m_idx, m_mode, m_div, m_hold;
    bit m_done, m_down;

    always #5 clk = ~clk;

    rgb_fade_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period_tick (period_tick),
        .step_div    (step_div),
        .hold_ticks  (hold_ticks),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .duty_r      (duty_r),
        .duty_g      (duty_g),
        .duty_b      (duty_b),
        .step_idx    (step_idx),
        .busy        (busy),
        .step_done   (step_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            for (int i = 0; i < N; i++) m_pal[i][c] = 0;
        end
        m_idx  = 0;
        m_mode = M_IDLE;
        m_div  = 0;
        m_hold = 0;
        m_done = 0;
        m_down = 0;
    endfunction

    function automatic int next_index(input int i);
`ifdef RGB_SEQ_PINGPONG_EN
        if (!m_down) begin
            if (i == N - 1) begin
                m_down = 1;
                return i - 1;
            end
            return i + 1;
        end
        if (i == 0) begin
            m_down = 0;
            return 1;
        end
        return i - 1;
`else
        return (i + 1) % N;
`endif
    endfunction

    function automatic void model_step();
        int  tgt [3];
        bit  arrived;
        arrived = 1;
        for (int c = 0; c < 3; c++) begin
            tgt[c] = m_pal[m_idx][c];
            if (m_duty[c] != tgt[c]) arrived = 0;
        end
        m_done = 0;
        if (!enable) begin
            m_mode = M_IDLE;
            m_div  = 0;
            m_hold = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FADE;
        end else if (m_mode == M_FADE) begin
            if (arrived) begin
                m_mode = M_HOLD;
                m_hold = 0;
            end else if (period_tick) begin
                if (m_div == int'(step_div)) begin
                    m_div = 0;
                    for (int c = 0; c < 3; c++) begin
                        if (m_duty[c] < tgt[c]) m_duty[c] = m_duty[c] + 1;
                        else if (m_duty[c] > tgt[c]) m_duty[c] = m_duty[c] - 1;
                    end
                end else begin
                    m_div = m_div + 1;
                end
            end
        end else begin
            if (period_tick) begin
                if (m_hold == int'(hold_ticks)) begin
                    m_idx  = next_index(m_idx);
                    m_done = 1;
                    m_mode = M_FADE;
                    m_div  = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
        if (cfg_we) begin
            m_pal[cfg_addr][0] = int'(cfg_data[23:16]);
            m_pal[cfg_addr][1] = int'(cfg_data[15:8]);
            m_pal[cfg_addr][2] = int'(cfg_data[7:0]);
        end
    endfunction

    // Reference model advances on every clock edge and resets asynchronously
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cyc_duty_r", duty_r, m_duty[0]);
                chk("cyc_duty_g", duty_g, m_duty[1]);
                chk("cyc_duty_b", duty_b, m_duty[2]);
                chk("cyc_step_idx", step_idx, m_idx);
                chk("cyc_busy", busy, (m_mode != M_IDLE));
                chk("cyc_step_done", step_done, m_done);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            period_tick = 1'b1;
            @(negedge clk);
            period_tick = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic wpal(input int a, input int r, input int g, input int b);
        rgb_seq_pkg::rgb_t c;
        c.r = r[7:0];
        c.g = g[7:0];
        c.b = b[7:0];
        cfg_we   = 1'b1;
        cfg_addr = a[1:0];
        cfg_data = c;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        enable      = 1'b0;
        period_tick = 1'b0;
        cfg_we      = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idx(input int want, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_idx === want[1:0]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int exp_idx;

        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_duty_r", duty_r, 0);
        chk("rst_duty_g", duty_g, 0);
        chk("rst_duty_b", duty_b, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_done", step_done, 0);

        // Basic fade, hold of 2, advance on the third tick
        wpal(0, 40, 0, 10);
        step_div   = 8'd0;
        hold_ticks = 8'd2;
        enable     = 1'b1;
        cyc(2);
        chk("s1_busy", busy, 1);
        ticks(10, 4);
        chk("s1_r_at10", duty_r, 10);
        chk("s1_b_at10", duty_b, 10);
        ticks(20, 4);
        chk("s1_r_at30", duty_r, 30);
        chk("s1_b_stays", duty_b, 10);
        chk("s1_g_zero", duty_g, 0);
        ticks(10, 4);
        chk("s1_r_at40", duty_r, 40);
        chk("s1_idx_before", step_idx, 0);
        ticks(2, 4);
        chk("s1_idx_hold", step_idx, 0);
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        chk("s1_done_pulse", step_done, 1);
        chk("s1_idx_adv", step_idx, 1);
        cyc(1);
        chk("s1_done_clear", step_done, 0);

        // Rate divider: one LSB per 4 ticks
        do_reset();
        wpal(0, 8, 0, 0);
        step_div   = 8'd3;
        hold_ticks = 8'd200;
        enable     = 1'b1;
        cyc(2);
        ticks(3, 2);
        chk("s2_r_3ticks", duty_r, 0);
        ticks(1, 2);
        chk("s2_r_4ticks", duty_r, 1);
        ticks(27, 2);
        chk("s2_r_31ticks", duty_r, 7);
        ticks(1, 2);
        chk("s2_r_32ticks", duty_r, 8);

        // Downward fade to zero and index wrap, tick held high
        do_reset();
        wpal(0, 5, 5, 5);
        wpal(1, 5, 5, 5);
        wpal(2, 5, 5, 5);
        wpal(3, 0, 0, 0);
        step_div    = 8'd0;
        hold_ticks  = 8'd0;
        enable      = 1'b1;
        period_tick = 1'b1;
        wait_idx(3, 60, ok);
        chk("s3_reach_idx3", ok, 1);
        chk("s3_r_at_idx3", duty_r, 5);
        wait_done(60, ok);
        chk("s3_done_seen", ok, 1);
`ifdef RGB_SEQ_PINGPONG_EN
        exp_idx = 2;
`else
        exp_idx = 0;
`endif
        chk("s3_idx_after", step_idx, exp_idx);
        chk("s3_r_zero", duty_r, 0);
        chk("s3_g_zero", duty_g, 0);
        chk("s3_b_zero", duty_b, 0);
        period_tick = 1'b0;

        // Freeze mid-fade and resume
        do_reset();
        wpal(0, 0, 40, 0);
        step_div   = 8'd0;
        hold_ticks = 8'd5;
        enable     = 1'b1;
        cyc(2);
        ticks(17, 2);
        chk("s4_g_17", duty_g, 17);
        enable = 1'b0;
        cyc(1);
        ticks(3, 2);
        chk("s4_g_frozen", duty_g, 17);
        chk("s4_busy_low", busy, 0);
        enable = 1'b1;
        cyc(2);
        ticks(3, 2);
        chk("s4_g_resumed", duty_g, 20);
        chk("s4_idx_same", step_idx, 0);

        // Palette write to current index coinciding with a tick
        do_reset();
        wpal(0, 20, 0, 0);
        step_div   = 8'd0;
        hold_ticks = 8'd255;
        enable     = 1'b1;
        cyc(2);
        ticks(10, 2);
        chk("s5_r_10", duty_r, 10);
        period_tick = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = 2'd0;
        cfg_data    = {8'd100, 8'd0, 8'd30};
        @(negedge clk);
        period_tick = 1'b0;
        cfg_we      = 1'b0;
        chk("s5_r_oldtgt", duty_r, 11);
        chk("s5_b_oldtgt", duty_b, 0);
        cyc(1);
        ticks(1, 2);
        chk("s5_r_newtgt", duty_r, 12);
        chk("s5_b_newtgt", duty_b, 1);

        // Reach HOLD, then asynchronous reset between edges
        period_tick = 1'b1;
        cyc(100);
        period_tick = 1'b0;
        cyc(2);
        chk("s6_r_100", duty_r, 100);
        chk("s6_b_30", duty_b, 30);
        chk("s6_busy_hold", busy, 1);
        chk("s6_idx_hold", step_idx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_r", duty_r, 0);
        chk("s6_async_b", duty_b, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_idx", step_idx, 0);
        cyc(1);
        rst_n = 1'b1;
        enable = 1'b1;
        cyc(2);
        ticks(3, 2);
        chk("s6_pal_cleared_r", duty_r, 0);
        chk("s6_pal_cleared_b", duty_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
